// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared codes for the multicycle RV32I control unit.
// States, opcodes, ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [5:0] {
    ST_FETCH    = 6'd0,
    ST_DECODE   = 6'd1,
    ST_MEMADDR  = 6'd2,
    ST_MEMREAD  = 6'd3,
    ST_MEMWB    = 6'd4,
    ST_MEMWRITE = 6'd5,
    ST_EXEC_R   = 6'd6,
    ST_EXEC_I   = 6'd7,
    ST_ALUWB    = 6'd8,
    ST_BRANCH   = 6'd9,
    ST_JAL      = 6'd10,
    ST_JALR     = 6'd11,
    ST_LUI      = 6'd12,
    ST_AUIPC    = 6'd13,
    ST_INVALID  = 6'd14,
    ST_ECALL    = 6'd15,
    ST_URET     = 6'd16,
    ST_CSR_EX   = 6'd17,
    ST_CSR_WB   = 6'd18
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [4:0] OPADD  = 5'd0;
  localparam logic [4:0] OPSUB  = 5'd1;
  localparam logic [4:0] OPAND  = 5'd2;
  localparam logic [4:0] OPOR   = 5'd3;
  localparam logic [4:0] OPXOR  = 5'd4;
  localparam logic [4:0] OPSLT  = 5'd5;
  localparam logic [4:0] OPSLTU = 5'd6;
  localparam logic [4:0] OPSLL  = 5'd7;
  localparam logic [4:0] OPSRL  = 5'd8;
  localparam logic [4:0] OPSRA  = 5'd9;

  localparam logic [2:0] A_REG    = 3'd0;
  localparam logic [2:0] A_PC     = 3'd1;
  localparam logic [2:0] A_PCBACK = 3'd2;
  localparam logic [2:0] A_IMM    = 3'd3;
  localparam logic [2:0] A_NOTA   = 3'd4;
  localparam logic [2:0] A_ZERO   = 3'd7;

  localparam logic [2:0] B_REG  = 3'd0;
  localparam logic [2:0] B_FOUR = 3'd1;
  localparam logic [2:0] B_IMM  = 3'd2;
  localparam logic [2:0] B_CSR  = 3'd3;
  localparam logic [2:0] B_ZERO = 3'd4;

  localparam logic [2:0] M_ALUOUT = 3'd0;
  localparam logic [2:0] M_PC     = 3'd1;
  localparam logic [2:0] M_MDR    = 3'd2;
  localparam logic [2:0] M_CSR    = 3'd4;

  localparam logic [2:0] P_ALU     = 3'd0;
  localparam logic [2:0] P_ALUOUT  = 3'd1;
  localparam logic [2:0] P_ALUMASK = 3'd2;
  localparam logic [2:0] P_UTVEC   = 3'd3;
  localparam logic [2:0] P_UEPC    = 3'd4;

  // alt selects SUB over ADD and SRA over SRL
  function automatic logic [4:0] aluFromF3(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [4:0] op;
    op = OPADD;
    case (f3)
      3'd0: op = alt ? OPSUB : OPADD;
      3'd1: op = OPSLL;
      3'd2: op = OPSLT;
      3'd3: op = OPSLTU;
      3'd4: op = OPXOR;
      3'd5: op = alt ? OPSRA : OPSRL;
      3'd6: op = OPOR;
      default: op = OPAND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_multi_alu_decode.sv
// alu_decode: opcode/funct3/funct7 to ALU code.
// Also flags funct encodings that RV32I does not define.
module alu_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [4:0] aluOp,
  output logic       illegal
);

  // funct decode and legality per instruction class
  always_comb begin
    aluOp   = OPADD;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        aluOp   = aluFromF3(funct3, funct7[5]);
        illegal = !(funct7 == 7'h00 ||
                    (funct7 == 7'h20 &&
                     (funct3 == 3'd0 || funct3 == 3'd5)));
      end
      OPC_OPIMM: begin
        aluOp = aluFromF3(funct3,
                          (funct3 == 3'd5) & funct7[5]);
        if (funct3 == 3'd1)
          illegal = funct7 != 7'h00;
        else if (funct3 == 3'd5)
          illegal = funct7 != 7'h00 && funct7 != 7'h20;
      end
      OPC_BRANCH: begin
        aluOp   = OPSUB;
        illegal = funct3 == 3'd2 || funct3 == 3'd3;
      end
      OPC_LOAD:
        illegal = funct3 == 3'd3 || funct3 >= 3'd6;
      OPC_STORE:
        illegal = funct3 >= 3'd3;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_multi.sv
// control_multi: multicycle RV32I Moore control FSM.
// Optional CSR/ecall/uret support under macro ZICSR_EN.
module control_multi
  import riscv_ctrl_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iInstr,
  output logic [5:0]  oState,
  output logic        oEscreveIR,
  output logic        oEscrevePC,
  output logic        oEscrevePCCond,
  output logic        oEscrevePCBack,
  output logic [2:0]  oOrigAULA,
  output logic [2:0]  oOrigBULA,
  output logic [2:0]  oMem2Reg,
  output logic [2:0]  oOrigPC,
  output logic        oIouD,
  output logic        oRegWrite,
  output logic        oCSRegWrite,
  output logic        oMemWrite,
  output logic        oMemRead,
  output logic [4:0]  oALUControl,
  output logic        oInvInstruction,
  output logic        oEcall
);

  state_t     state;
  state_t     nxt;
  state_t     sysNext;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] aluOp;
  logic       illegal;
  logic       unusedBits;

  assign opcode = iInstr[6:0];
  assign funct3 = iInstr[14:12];
  assign funct7 = iInstr[31:25];
  assign oState = state;
  assign unusedBits = ^iInstr;

  alu_decode uAluDec (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .aluOp  (aluOp),
    .illegal(illegal)
  );

  // state register; reset parks in FETCH
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= ST_FETCH;
    else      state <= nxt;
  end

  // SYSTEM opcode dispatch target
  always_comb begin
    sysNext = ST_INVALID;
`ifdef ZICSR_EN
    if (funct3 == 3'd0) begin
      if (iInstr[31:20] == 12'h000)
        sysNext = ST_ECALL;
      else if (iInstr[31:20] == 12'h002)
        sysNext = ST_URET;
    end else if (funct3 != 3'd4) begin
      sysNext = ST_CSR_EX;
    end
`endif
  end

  // next-state logic
  always_comb begin
    nxt = ST_FETCH;
    case (state)
      ST_FETCH: nxt = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OPC_LOAD,
          OPC_STORE:  nxt = ST_MEMADDR;
          OPC_OP:     nxt = ST_EXEC_R;
          OPC_OPIMM:  nxt = ST_EXEC_I;
          OPC_BRANCH: nxt = ST_BRANCH;
          OPC_JAL:    nxt = ST_JAL;
          OPC_JALR:   nxt = ST_JALR;
          OPC_LUI:    nxt = ST_LUI;
          OPC_AUIPC:  nxt = ST_AUIPC;
          OPC_SYSTEM: nxt = sysNext;
          default:    nxt = ST_INVALID;
        endcase
        if (illegal) nxt = ST_INVALID;
      end
      ST_MEMADDR:
        nxt = (opcode == OPC_STORE) ? ST_MEMWRITE
                                    : ST_MEMREAD;
      ST_MEMREAD: nxt = ST_MEMWB;
      ST_EXEC_R,
      ST_EXEC_I,
      ST_LUI,
      ST_AUIPC:   nxt = ST_ALUWB;
      ST_CSR_EX:  nxt = ST_CSR_WB;
      default:    nxt = ST_FETCH;
    endcase
  end

  // Moore output decode, forced idle during reset
  always_comb begin
    oEscreveIR      = 1'b0;
    oEscrevePC      = 1'b0;
    oEscrevePCCond  = 1'b0;
    oEscrevePCBack  = 1'b0;
    oOrigAULA       = A_REG;
    oOrigBULA       = B_REG;
    oMem2Reg        = M_ALUOUT;
    oOrigPC         = P_ALU;
    oIouD           = 1'b0;
    oRegWrite       = 1'b0;
    oCSRegWrite     = 1'b0;
    oMemWrite       = 1'b0;
    oMemRead        = 1'b0;
    oALUControl     = OPADD;
    oInvInstruction = 1'b0;
    oEcall          = 1'b0;
    if (!iRST) begin
      case (state)
        ST_FETCH: begin
          oMemRead       = 1'b1;
          oEscreveIR     = 1'b1;
          oEscrevePCBack = 1'b1;
          oEscrevePC     = 1'b1;
          oOrigAULA      = A_PC;
          oOrigBULA      = B_FOUR;
        end
        ST_DECODE: begin
          oOrigAULA = A_PCBACK;
          oOrigBULA = B_IMM;
        end
        ST_MEMADDR: begin
          oOrigAULA = A_REG;
          oOrigBULA = B_IMM;
        end
        ST_MEMREAD: begin
          oIouD    = 1'b1;
          oMemRead = 1'b1;
        end
        ST_MEMWB: begin
          oIouD     = 1'b1;
          oRegWrite = 1'b1;
          oMem2Reg  = M_MDR;
        end
        ST_MEMWRITE: begin
          oIouD     = 1'b1;
          oMemWrite = 1'b1;
        end
        ST_EXEC_R: begin
          oOrigBULA   = B_REG;
          oALUControl = aluOp;
        end
        ST_EXEC_I: begin
          oOrigBULA   = B_IMM;
          oALUControl = aluOp;
        end
        ST_LUI: begin
          oOrigAULA = A_ZERO;
          oOrigBULA = B_IMM;
        end
        ST_AUIPC: begin
          oOrigAULA = A_PCBACK;
          oOrigBULA = B_IMM;
        end
        ST_ALUWB: begin
          oRegWrite = 1'b1;
          oMem2Reg  = M_ALUOUT;
        end
        ST_BRANCH: begin
          oEscrevePCCond = 1'b1;
          oOrigPC        = P_ALUOUT;
        end
        ST_JAL: begin
          oRegWrite  = 1'b1;
          oMem2Reg   = M_PC;
          oEscrevePC = 1'b1;
          oOrigPC    = P_ALUOUT;
        end
        ST_JALR: begin
          oOrigBULA  = B_IMM;
          oEscrevePC = 1'b1;
          oOrigPC    = P_ALUMASK;
          oRegWrite  = 1'b1;
          oMem2Reg   = M_PC;
        end
        ST_INVALID: oInvInstruction = 1'b1;
`ifdef ZICSR_EN
        ST_ECALL: begin
          oEcall     = 1'b1;
          oOrigPC    = P_UTVEC;
          oEscrevePC = 1'b1;
        end
        ST_URET: begin
          oOrigPC    = P_UEPC;
          oEscrevePC = 1'b1;
        end
        ST_CSR_EX: begin
          oOrigAULA = funct3[2] ? A_IMM : A_REG;
          case (funct3[1:0])
            2'b10: begin
              oOrigBULA   = B_CSR;
              oALUControl = OPOR;
            end
            2'b11: begin
              oOrigBULA   = B_CSR;
              oALUControl = OPAND;
              if (!funct3[2]) oOrigAULA = A_NOTA;
            end
            default: oOrigBULA = B_ZERO;
          endcase
        end
        ST_CSR_WB: begin
          oRegWrite   = 1'b1;
          oMem2Reg    = M_CSR;
          oCSRegWrite = !(funct3[1] &&
                          iInstr[19:15] == 5'd0);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multi.sv
// tb_control_multi: directed bench for control_multi.
// Instruction-class model plus literal CPI and reset checks.
module tb_control_multi;
  import riscv_ctrl_pkg::*;

  logic        iCLK;
  logic        iRST;
  logic [31:0] iInstr;
  logic [5:0]  oState;
  logic        oEscreveIR, oEscrevePC;
  logic        oEscrevePCCond, oEscrevePCBack;
  logic [2:0]  oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC;
  logic        oIouD, oRegWrite, oCSRegWrite;
  logic        oMemWrite, oMemRead;
  logic [4:0]  oALUControl;
  logic        oInvInstruction, oEcall;

  control_multi dut (
    .iCLK(iCLK), .iRST(iRST), .iInstr(iInstr),
    .oState(oState),
    .oEscreveIR(oEscreveIR), .oEscrevePC(oEscrevePC),
    .oEscrevePCCond(oEscrevePCCond),
    .oEscrevePCBack(oEscrevePCBack),
    .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA),
    .oMem2Reg(oMem2Reg), .oOrigPC(oOrigPC),
    .oIouD(oIouD), .oRegWrite(oRegWrite),
    .oCSRegWrite(oCSRegWrite), .oMemWrite(oMemWrite),
    .oMemRead(oMemRead), .oALUControl(oALUControl),
    .oInvInstruction(oInvInstruction), .oEcall(oEcall)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [5:0] st;
    logic       ir, pc, pcc, pcb;
    logic [2:0] a, b, m2r, opc;
    logic       iou, rw, csrw, mw, mr;
    logic [4:0] alu;
    logic       inv, ec;
  } obs_t;

  typedef enum int {
    C_LOAD, C_STORE, C_R, C_I, C_LUI, C_AUIPC,
    C_BR, C_JAL, C_JALR, C_INV, C_ECALL, C_URET, C_CSR
  } cls_t;

  typedef struct {
    logic [31:0] w;
    cls_t        c;
    logic [4:0]  alu;
    logic        csrw;
  } vec_t;

  obs_t obs;
  assign obs = {oState, oEscreveIR, oEscrevePC,
                oEscrevePCCond, oEscrevePCBack,
                oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC,
                oIouD, oRegWrite, oCSRegWrite,
                oMemWrite, oMemRead, oALUControl,
                oInvInstruction, oEcall};

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  vec_t cur;
  int   curStep = 0;
  bit   active = 1'b0;

  function automatic int seqLen(cls_t c);
    case (c)
      C_LOAD: return 5;
      C_STORE, C_R, C_I, C_LUI, C_AUIPC, C_CSR: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic logic [5:0] phaseOf(cls_t c, int k);
    case (c)
      C_LOAD:  return k == 0 ? ST_MEMADDR :
                      k == 1 ? ST_MEMREAD : ST_MEMWB;
      C_STORE: return k == 0 ? ST_MEMADDR : ST_MEMWRITE;
      C_R:     return k == 0 ? ST_EXEC_R : ST_ALUWB;
      C_I:     return k == 0 ? ST_EXEC_I : ST_ALUWB;
      C_LUI:   return k == 0 ? ST_LUI : ST_ALUWB;
      C_AUIPC: return k == 0 ? ST_AUIPC : ST_ALUWB;
      C_CSR:   return k == 0 ? ST_CSR_EX : ST_CSR_WB;
      C_BR:    return ST_BRANCH;
      C_JAL:   return ST_JAL;
      C_JALR:  return ST_JALR;
      C_ECALL: return ST_ECALL;
      C_URET:  return ST_URET;
      default: return ST_INVALID;
    endcase
  endfunction

  function automatic obs_t model(vec_t v, int s);
    obs_t       e;
    logic [5:0] ph;
    logic [2:0] f3;
    e  = '0;
    f3 = v.w[14:12];
    if (s == 0)      ph = ST_FETCH;
    else if (s == 1) ph = ST_DECODE;
    else             ph = phaseOf(v.c, s - 2);
    e.st = ph;
    case (ph)
      ST_FETCH: begin
        e.mr = 1; e.ir = 1; e.pcb = 1; e.pc = 1;
        e.a = 3'd1; e.b = 3'd1; e.alu = OPADD;
      end
      ST_DECODE: begin
        e.a = 3'd2; e.b = 3'd2; e.alu = OPADD;
      end
      ST_MEMADDR: begin
        e.a = 3'd0; e.b = 3'd2; e.alu = OPADD;
      end
      ST_MEMREAD: begin e.iou = 1; e.mr = 1; end
      ST_MEMWB: begin
        e.iou = 1; e.rw = 1; e.m2r = 3'd2;
      end
      ST_MEMWRITE: begin e.iou = 1; e.mw = 1; end
      ST_EXEC_R: begin
        e.a = 3'd0; e.b = 3'd0; e.alu = v.alu;
      end
      ST_EXEC_I: begin
        e.a = 3'd0; e.b = 3'd2; e.alu = v.alu;
      end
      ST_LUI: begin e.a = 3'd7; e.b = 3'd2; end
      ST_AUIPC: begin e.a = 3'd2; e.b = 3'd2; end
      ST_ALUWB: begin e.rw = 1; e.m2r = 3'd0; end
      ST_BRANCH: begin e.pcc = 1; e.opc = 3'd1; end
      ST_JAL: begin
        e.rw = 1; e.m2r = 3'd1; e.pc = 1; e.opc = 3'd1;
      end
      ST_JALR: begin
        e.a = 3'd0; e.b = 3'd2; e.alu = OPADD;
        e.pc = 1; e.opc = 3'd2; e.rw = 1; e.m2r = 3'd1;
      end
      ST_INVALID: e.inv = 1;
      ST_ECALL: begin e.ec = 1; e.opc = 3'd3; e.pc = 1; end
      ST_URET: begin e.opc = 3'd4; e.pc = 1; end
      ST_CSR_EX: begin
        e.alu = v.alu;
        if (f3[1:0] == 2'b01) e.b = 3'd4;
        else                  e.b = 3'd3;
        if (f3[2])                  e.a = 3'd3;
        else if (f3[1:0] == 2'b11)  e.a = 3'd4;
        else                        e.a = 3'd0;
      end
      ST_CSR_WB: begin
        e.rw = 1; e.m2r = 3'd4; e.csrw = v.csrw;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chkObs(string nm, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s instr %h step %0d got %h want %h",
               nm, cur.w, curStep, got, exp);
    end
  endtask

  task automatic chkVal(string nm, logic [31:0] got,
                        logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  // per-cycle compare against the model or the reset image
  always @(negedge iCLK) begin
    if (iRST)
      chkObs("reset", obs, '0);
    else if (active)
      chkObs("model", obs, model(cur, curStep));
  end

  task automatic runSteps(vec_t v, int n);
    for (int s = 0; s < n; s++) begin
      cur     = v;
      curStep = s;
      iInstr  = v.w;
      active  = 1'b1;
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic measureCpi(string nm, logic [31:0] w,
                            int exp);
    int n;
    active = 1'b0;
    iInstr = w;
    n = 0;
    do begin
      @(posedge iCLK);
      #1;
      n++;
    end while (oState != ST_FETCH && n < 20);
    chkVal(nm, 32'(n), 32'(exp));
  endtask

  task automatic addVec(logic [31:0] w, cls_t c,
                        logic [4:0] alu, logic csrw);
    vec_t v;
    v.w = w; v.c = c; v.alu = alu; v.csrw = csrw;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t lw;
    iRST   = 1'b1;
    iInstr = 32'h0;
    addVec(32'h002081B3, C_R,     OPADD,  0);
    addVec(32'h402081B3, C_R,     OPSUB,  0);
    addVec(32'h407352B3, C_R,     OPSRA,  0);
    addVec(32'h003130B3, C_R,     OPSLTU, 0);
    addVec(32'h022081B3, C_INV,   OPADD,  0);
    addVec(32'h00500093, C_I,     OPADD,  0);
    addVec(32'hFFF0C113, C_I,     OPXOR,  0);
    addVec(32'h4021D193, C_I,     OPSRA,  0);
    addVec(32'h40209093, C_INV,   OPADD,  0);
    addVec(32'h00812283, C_LOAD,  OPADD,  0);
    addVec(32'h00813283, C_INV,   OPADD,  0);
    addVec(32'h00512423, C_STORE, OPADD,  0);
    addVec(32'h00513423, C_INV,   OPADD,  0);
    addVec(32'h00208463, C_BR,    OPADD,  0);
    addVec(32'h0020A463, C_INV,   OPADD,  0);
    addVec(32'h010000EF, C_JAL,   OPADD,  0);
    addVec(32'h000280E7, C_JALR,  OPADD,  0);
    addVec(32'h123452B7, C_LUI,   OPADD,  0);
    addVec(32'h00001317, C_AUIPC, OPADD,  0);
    addVec(32'h0000007F, C_INV,   OPADD,  0);
`ifdef ZICSR_EN
    addVec(32'h00002273, C_CSR,   OPOR,   0);
    addVec(32'h00009073, C_CSR,   OPADD,  1);
    addVec(32'h0001F173, C_CSR,   OPAND,  1);
    addVec(32'h00000073, C_ECALL, OPADD,  0);
    addVec(32'h00200073, C_URET,  OPADD,  0);
`else
    addVec(32'h00002273, C_INV,   OPADD,  0);
    addVec(32'h00009073, C_INV,   OPADD,  0);
    addVec(32'h0001F173, C_INV,   OPADD,  0);
    addVec(32'h00000073, C_INV,   OPADD,  0);
    addVec(32'h00200073, C_INV,   OPADD,  0);
`endif

    repeat (2) @(posedge iCLK);
    #1;
    chkVal("rst_state", 32'(oState), 32'd0);
    iRST = 1'b0;
    #1;
    chkVal("rel_ir", 32'(oEscreveIR), 32'd1);
    chkVal("rel_pc", 32'(oEscrevePC), 32'd1);

    foreach (vecs[i]) runSteps(vecs[i], seqLen(vecs[i].c));

    lw = vecs[9];
    runSteps(lw, 3);
    active = 1'b0;
    #1;
    chkVal("memread_pre", 32'(oMemRead), 32'd1);
    chkVal("memread_st", 32'(oState), 32'd3);
    iRST = 1'b1;
    #1;
    chkVal("rst_memread", 32'(oMemRead), 32'd0);
    chkVal("rst_mid_st", 32'(oState), 32'd0);
    @(posedge iCLK);
    #1;
    chkVal("rst_hold_st", 32'(oState), 32'd0);
    chkVal("rst_hold_iou", 32'(oIouD), 32'd0);
    iRST = 1'b0;
    #1;
    chkVal("post_ir", 32'(oEscreveIR), 32'd1);
    chkVal("post_pc", 32'(oEscrevePC), 32'd1);

    runSteps(vecs[0], 4);
    active = 1'b0;
    measureCpi("cpi_add",  32'h002081B3, 4);
    measureCpi("cpi_lw",   32'h00812283, 5);
    measureCpi("cpi_sw",   32'h00512423, 4);
    measureCpi("cpi_beq",  32'h00208463, 3);
    measureCpi("cpi_jalr", 32'h000280E7, 3);
    measureCpi("cpi_inv",  32'h0000007F, 3);

    iInstr = 32'h000280E7;
    repeat (2) begin
      @(posedge iCLK);
      #1;
    end
    chkVal("jalr_st",  32'(oState), 32'd11);
    chkVal("jalr_opc", 32'(oOrigPC), 32'd2);
    chkVal("jalr_m2r", 32'(oMem2Reg), 32'd1);
    chkVal("jalr_rw",  32'(oRegWrite), 32'd1);
    @(posedge iCLK);
    #1;
    chkVal("jalr_back", 32'(oState), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_multi.md
# control_multi

Multicycle RV32I control unit that drives the multicycle datapath's control inputs. A 6-bit-encoded Moore FSM steps each instruction through FETCH/DECODE/execute/writeback. It decodes the datapath's instruction register to issue write enables, mux selects and ALU operations. It also flags illegal instructions and `ecall` to the exception path, and reports its state so exception capture is state-aware.

## Interface
- No parameters; state, opcode and ALU codes come from the shared package.
- `iCLK` in 1: sole clock; all state changes on rising edge.
- `iRST` in 1: asynchronous, active-high reset.
- `iInstr` in 32: current IR contents; `opcode=[6:0]`, `funct3=[14:12]`, `funct7=[31:25]`, `rs1=[19:15]`.
- `oState` out 6: current state code.
- `oEscreveIR`, `oEscrevePC`, `oEscrevePCCond`, `oEscrevePCBack` out 1 each: register write enables.
- `oOrigAULA`, `oOrigBULA`, `oMem2Reg`, `oOrigPC` out 3 each: datapath mux selects (encodings below).
- `oIouD` out 1: 0 = PC address, 1 = ALUOut address.
- `oRegWrite`, `oCSRegWrite`, `oMemWrite`, `oMemRead` out 1 each: write and read strobes.
- `oALUControl` out 5: ALU operation code.
- `oInvInstruction`, `oEcall` out 1 each: exception requests.

## Operation
- **Mux encodings:**
  - `OrigAULA`: 0=A, 1=PC, 2=PCBack, 3=Imm, 4=~A, 7=zero.
  - `OrigBULA`: 0=B, 1=4, 2=Imm, 3=CSR, 4=zero.
  - `Mem2Reg`: 0=ALUOut, 1=PC, 2=MDR, 4=CSR.
  - `OrigPC`: 0=ALU, 1=ALUOut, 2=ALU&~1, 3=UTVEC, 4=UEPC.
- **Output decode:** outputs decode combinationally from the state register plus `iInstr` fields. Any output not listed for a state is 0.
- **FETCH:**
  - Outputs: `MemRead`, `IouD=0`, `EscreveIR`, `EscrevePCBack`, `EscrevePC`, `OrigA=1`, `OrigB=1`, `OrigPC=0`, ALU=OPADD.
  - Next state: DECODE.
- **DECODE:**
  - Outputs: `OrigA=2`, `OrigB=2`, OPADD, which latches the branch/jal target into ALUOut.
  - Dispatch on opcode: load→MEMADDR, store→MEMADDR, OP→EXEC_R, OP-IMM→EXEC_I, BRANCH→BRANCH, JAL→JAL, JALR→JALR, LUI→LUI, AUIPC→AUIPC, SYSTEM→SYS, any other→INVALID.
- **MEMADDR:** `OrigA=0`, `OrigB=2`, OPADD. Next: MEMREAD for loads, MEMWRITE for stores.
- **MEMREAD:** `IouD=1`, `MemRead`. Next: MEMWB.
- **MEMWB:** `IouD=1`, `RegWrite`, `Mem2Reg=2`. Next: FETCH.
- **MEMWRITE:** `IouD=1`, `MemWrite`. Next: FETCH.
- **EXEC_R:** `OrigA=0`, `OrigB=0`, ALU code from funct3/funct7. Next: ALUWB.
- **EXEC_I:** `OrigA=0`, `OrigB=2`; ALU code from funct3, with `funct7[5]` considered only for shifts. Next: ALUWB.
- **LUI:** `OrigA=7`, `OrigB=2`, OPADD. Next: ALUWB.
- **AUIPC:** `OrigA=2`, `OrigB=2`, OPADD. Next: ALUWB.
- **ALUWB:** `RegWrite`, `Mem2Reg=0`. Next: FETCH.
- **BRANCH:** `EscrevePCCond`, `OrigPC=1`. Next: FETCH.
- **JAL:** `RegWrite`, `Mem2Reg=1`, `EscrevePC`, `OrigPC=1`. Next: FETCH.
- **JALR:** `OrigA=0`, `OrigB=2`, OPADD, `EscrevePC`, `OrigPC=2`, `RegWrite`, `Mem2Reg=1`. Next: FETCH. When rd==rs1, the jump uses the A value latched earlier.
- **INVALID:** `oInvInstruction=1`. Next: FETCH.
- **Illegal funct encodings:** an illegal funct3/funct7 combination in OP, OP-IMM, BRANCH or load/store (funct3 3,6,7 for loads; ≥3 for stores) goes to INVALID from DECODE.

## Timing
- **CPI:** load 5; store, R-type, I-type, LUI, AUIPC 4; branch, JAL, JALR 3; ecall, uret, invalid 3; CSR 4.
- **Reset:** while `iRST`=1, state=FETCH and every output is forced 0 except `oState`=ST_FETCH.
- **Release:** the first FETCH occurs on the first rising edge after `iRST` falls.
- **Reset mid-instruction:** abandons the instruction immediately; no further strobes are issued.
- **Strobe width:** every strobe lasts exactly one cycle per state visit.

## Configuration
- `ZICSR_EN` defined:
  - SYSTEM opcode with funct3=0: imm 0 → ECALL; imm 0x002 → URET.
  - ECALL: `oEcall`, `OrigPC=3`, `EscrevePC`.
  - URET: `OrigPC=4`, `EscrevePC`.
  - CSRRW/S/C(I) → CSR_EX → CSR_WB.
  - CSR_EX: RW uses `OrigA=0`/`OrigB=4`/OPADD; RS uses `OrigA=0`/`OrigB=3`/OPOR; RC uses `OrigA=4`/`OrigB=3`/OPAND. The I-forms use `OrigA=3` (RC I-form: uimm inverted inside the ALU path, with zimm from ImmGen).
  - CSR_WB: `RegWrite`, `Mem2Reg=4`. `CSRegWrite` is asserted unless the instruction is RS/RC with rs1/uimm==0.
- `ZICSR_EN` undefined:
  - All SYSTEM opcodes go to INVALID.
  - `oCSRegWrite` and `oEcall` are tied 0; `OrigPC` never takes values 3 or 4.

## Structure
- **Package `riscv_ctrl_pkg`** holds:
  - state codes ST_* (ST_FETCH=0, ST_DECODE=1, …);
  - opcode constants;
  - ALU codes OPADD, OPSUB, OPAND, OPOR, OPXOR, OPSLT, OPSLTU, OPSLL, OPSRL, OPSRA;
  - mux select constants.
- **Sub-module `alu_decode`:** purely combinational mapping of opcode, funct3 and funct7 to the ALU code plus an illegal flag.

## Test plan
- **Reset:** `iRST` pulsed mid-MEMREAD → `oMemRead`=0 during reset and `oState`=0; first post-reset cycle shows `oEscreveIR`=1 and `oEscrevePC`=1.
- **R-type:** `add x3,x1,x2` (0x002081B3) → states 0,1,EXEC_R,ALUWB; ALU=OPADD with `OrigA`=0/`OrigB`=0; `oRegWrite`=1 only in ALUWB; 4 cycles.
- **Load/store:** `lw x5,8(x2)` → 5 cycles; `oIouD`=1 in MEMREAD and MEMWB; `Mem2Reg`=2. `sw` → `oMemWrite` pulses exactly 1 cycle and `oRegWrite` never asserts.
- **Branch and jump:** `beq` → `oEscrevePCCond`=1 with `OrigPC`=1 in cycle 3. `jalr x1,0(x5)` → `OrigPC`=2, `Mem2Reg`=1 and `oRegWrite`=1 in the same cycle.
- **Illegal:** opcode 0x7F, or funct3=3 on STORE → INVALID state with `oInvInstruction`=1 for one cycle, then FETCH.
- **ZICSR_EN:** `csrrs x4,ustatus,x0` → `oCSRegWrite`=0 and `oRegWrite`=1 in CSR_WB. `ecall` → `oEcall`=1 with `OrigPC`=3. Without the macro, the same words → `oInvInstruction`=1.
